// File: rtl/pbit_pkg.sv
// Shared types and constants for the p-bit synapse scheduler.
// Also defines the saturation bounds for the 8-bit weighted input.
package pbit_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StSat,
        StIssue
    } state_e;

    localparam int unsigned DEF_N_PBITS   = 4;
    localparam int unsigned DEF_W_WIDTH   = 8;
    localparam int unsigned DEF_ACC_WIDTH = 16;

    localparam int unsigned SAT_WIDTH = 8;
    localparam int          SAT_MAX   = 127;
    localparam int          SAT_MIN   = -128;

    // Index width for n entries, never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/synapse_mac.sv
// Signed add/subtract accumulator with preload and clamp to the 8-bit output range.
module synapse_mac
    import pbit_pkg::*;
#(
    parameter int unsigned W_WIDTH   = DEF_W_WIDTH,
    parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        load,
    input  logic signed [ACC_WIDTH-1:0] preload,
    input  logic                        en,
    input  logic                        sub,
    input  logic signed [W_WIDTH-1:0]   operand,
    output logic signed [SAT_WIDTH-1:0] sat
);

    localparam logic signed [ACC_WIDTH-1:0] AccMax = ACC_WIDTH'(SAT_MAX);
    localparam logic signed [ACC_WIDTH-1:0] AccMin = ACC_WIDTH'(SAT_MIN);
    localparam logic signed [SAT_WIDTH-1:0] SatMax = SAT_WIDTH'(SAT_MAX);
    localparam logic signed [SAT_WIDTH-1:0] SatMin = SAT_WIDTH'(SAT_MIN);

    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [ACC_WIDTH-1:0] acc_d;
    logic signed [ACC_WIDTH-1:0] operand_ext;

    assign operand_ext = {{(ACC_WIDTH - W_WIDTH){operand[W_WIDTH-1]}}, operand};

    always_comb begin
        acc_d = acc_q;
        if (load) begin
            acc_d = preload;
        end else if (en) begin
            acc_d = sub ? (acc_q - operand_ext) : (acc_q + operand_ext);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    always_comb begin
        if (acc_q > AccMax) begin
            sat = SatMax;
        end else if (acc_q < AccMin) begin
            sat = SatMin;
        end else begin
            sat = acc_q[SAT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/pbit_synapse_scheduler.sv
// Sequential synapse scheduler: accumulates J*m (+ optional bias) row by row, issues one-hot
// update strobes. Optional bias storage enabled by defining PBIT_SYNAPSE_BIAS_EN.
module pbit_synapse_scheduler
    import pbit_pkg::*;
#(
    parameter int unsigned N_PBITS   = DEF_N_PBITS,
    parameter int unsigned W_WIDTH   = DEF_W_WIDTH,
    parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              run,
    input  logic [N_PBITS-1:0]                m,
    input  logic                              wr_en,
    input  logic                              wr_bias,
    input  logic [idx_width(N_PBITS)-1:0]     wr_row,
    input  logic [idx_width(N_PBITS)-1:0]     wr_col,
    input  logic signed [W_WIDTH-1:0]         wr_data,
    output logic signed [SAT_WIDTH-1:0]       I_out,
    output logic [N_PBITS-1:0]                pbit_enable,
    output logic                              busy
);

    localparam int unsigned IdxW = idx_width(N_PBITS);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N_PBITS - 1);

    if (ACC_WIDTH < W_WIDTH + $clog2(N_PBITS) + 2) begin : g_acc_width_check
        $error("ACC_WIDTH too small for W_WIDTH and N_PBITS");
    end
    if (N_PBITS < 2 || N_PBITS > 64) begin : g_n_pbits_check
        $error("N_PBITS must be in 2..64");
    end

    state_e                      state_q;
    state_e                      state_d;
    logic [IdxW-1:0]             col_q;
    logic [IdxW-1:0]             col_d;
    logic [IdxW-1:0]             i_q;
    logic [IdxW-1:0]             i_d;
    logic signed [W_WIDTH-1:0]   j_mem [N_PBITS][N_PBITS];
    logic signed [ACC_WIDTH-1:0] preload;
    logic signed [SAT_WIDTH-1:0] sat;
    logic                        mac_load;
    logic                        mac_en;
    logic                        w_wr;
    logic                        addr_ok;

    assign addr_ok = (32'(wr_row) < N_PBITS) && (32'(wr_col) < N_PBITS);
    assign w_wr    = wr_en && !wr_bias && addr_ok;

    // Reads are combinational from the array, so a same-cycle write is seen only afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            j_mem <= '{default: '0};
        end else if (w_wr) begin
            j_mem[wr_row][wr_col] <= wr_data;
        end
    end

`ifdef PBIT_SYNAPSE_BIAS_EN
    logic signed [W_WIDTH-1:0] h_mem [N_PBITS];
    logic                      h_wr;

    assign h_wr = wr_en && wr_bias && (32'(wr_row) < N_PBITS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_mem <= '{default: '0};
        end else if (h_wr) begin
            h_mem[wr_row] <= wr_data;
        end
    end

    // Preload uses the row about to be accumulated, which is i_d across an ISSUE boundary.
    assign preload = {{(ACC_WIDTH - W_WIDTH){h_mem[i_d][W_WIDTH-1]}}, h_mem[i_d]};
`else
    assign preload = '0;
`endif

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        i_d     = i_q;
        unique case (state_q)
            StIdle: begin
                col_d = '0;
                if (run) begin
                    state_d = StAccum;
                end
            end
            StAccum: begin
                if (col_q == LastIdx) begin
                    col_d   = '0;
                    state_d = StSat;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            StSat: begin
                state_d = StIssue;
            end
            StIssue: begin
                i_d     = (i_q == LastIdx) ? '0 : i_q + 1'b1;
                state_d = run ? StAccum : StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            col_q   <= '0;
            i_q     <= '0;
            I_out   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            i_q     <= i_d;
            if (state_q == StSat) begin
                I_out <= sat;
            end
        end
    end

    assign mac_load = (state_d == StAccum) && (state_q != StAccum);
    // Self-coupling is skipped so J[i][i] never influences p-bit i.
    assign mac_en   = (state_q == StAccum) && (col_q != i_q);

    synapse_mac #(
        .W_WIDTH   (W_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_mac (
        .clk     (clk),
        .reset   (reset),
        .load    (mac_load),
        .preload (preload),
        .en      (mac_en),
        .sub     (!m[col_q]),
        .operand (j_mem[i_q][col_q]),
        .sat     (sat)
    );

    always_comb begin
        pbit_enable = '0;
        if (state_q == StIssue) begin
            pbit_enable[i_q] = 1'b1;
        end
    end

    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_pbit_synapse_scheduler.sv
// Scoreboard bench for pbit_synapse_scheduler (N_PBITS=4); expectations follow PBIT_SYNAPSE_BIAS_EN.
module tb_pbit_synapse_scheduler;

    localparam int N   = 4;
    localparam int UPD = N + 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              run;
    logic [3:0]        m;
    logic              wr_en;
    logic              wr_bias;
    logic [1:0]        wr_row;
    logic [1:0]        wr_col;
    logic signed [7:0] wr_data;
    logic signed [7:0] I_out;
    logic [3:0]        pbit_enable;
    logic              busy;

    typedef struct {
        int en;
        int iout;
        int cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   jm[N][N];
    int   hm[N];
    int   mdl_i;
    int   cyc;
    int   n_checks;
    int   n_errors;

    pbit_synapse_scheduler #(
        .N_PBITS   (4),
        .W_WIDTH   (8),
        .ACC_WIDTH (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .m           (m),
        .wr_en       (wr_en),
        .wr_bias     (wr_bias),
        .wr_row      (wr_row),
        .wr_col      (wr_col),
        .wr_data     (wr_data),
        .I_out       (I_out),
        .pbit_enable (pbit_enable),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model_iout(input int i, input logic [3:0] mv);
        int acc;
        acc = hm[i];
        for (int j = 0; j < N; j++) begin
            if (j != i) acc += mv[j] ? jm[i][j] : -jm[i][j];
        end
        if (acc > 127) acc = 127;
        if (acc < -128) acc = -128;
        return acc;
    endfunction

    task automatic push_exp(input int at);
        exp_t e;
        e.en   = 1 << mdl_i;
        e.iout = model_iout(mdl_i, m);
        e.cyc  = at;
        sb.push_back(e);
        mdl_i = (mdl_i + 1) % N;
    endtask

    always @(negedge clk) begin
        if (!reset && pbit_enable != 4'b0000) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_pulse", int'(pbit_enable), 0);
            end else begin
                mon_e = sb.pop_front();
                check_eq("enable", int'(pbit_enable), mon_e.en);
                check_eq("i_out", int'(I_out), mon_e.iout);
                check_eq("pulse_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic do_reset();
        reset   = 1'b1;
        run     = 1'b0;
        wr_en   = 1'b0;
        wr_bias = 1'b0;
        wr_row  = '0;
        wr_col  = '0;
        wr_data = '0;
        m       = '0;
        @(negedge clk);
        check_eq("rst_iout", int'(I_out), 0);
        check_eq("rst_enable", int'(pbit_enable), 0);
        check_eq("rst_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        foreach (jm[a, b]) jm[a][b] = 0;
        foreach (hm[a]) hm[a] = 0;
        mdl_i = 0;
    endtask

    task automatic write_w(input int r, input int c, input int v);
        wr_en   = 1'b1;
        wr_bias = 1'b0;
        wr_row  = 2'(r);
        wr_col  = 2'(c);
        wr_data = 8'(v);
        if (r < N && c < N) jm[r][c] = v;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic write_h(input int r, input int v);
        wr_en   = 1'b1;
        wr_bias = 1'b1;
        wr_row  = 2'(r);
        wr_col  = '0;
        wr_data = 8'(v);
`ifdef PBIT_SYNAPSE_BIAS_EN
        if (r < N) hm[r] = v;
`endif
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        wr_bias = 1'b0;
    endtask

    // Called just after a rising edge; that cycle is cycle 0 of the first update.
    task automatic run_updates(input int count, input logic [3:0] mval);
        int start;
        m     = mval;
        run   = 1'b1;
        start = cyc;
        for (int k = 0; k < count; k++) begin
            push_exp(start + UPD * (k + 1));
            if (k == count - 1) begin
                @(posedge clk);
                #1;
                run = 1'b0;
            end else begin
                repeat (UPD) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("idle_timeout", int'(n < 100), 1);
        repeat (2) @(negedge clk);
        check_eq("sb_drain", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Zero weights, all spins up.
        run_updates(1, 4'b1111);
        wait_idle();

        // Small weights plus bias on row 0.
        do_reset();
        write_w(0, 1, 5);
        write_w(0, 2, -3);
        write_h(0, 10);
        run_updates(1, 4'b0110);
        wait_idle();

        // Saturation, diagonal suppression, row wrap.
        do_reset();
        write_w(0, 1, 100);
        write_w(0, 2, 100);
        write_w(0, 3, 100);
        write_w(1, 1, 50);
        write_w(2, 0, -7);
        write_w(3, 2, 9);
        run_updates(2, 4'b1110);
        wait_idle();
        run_updates(3, 4'b0000);
        wait_idle();

        // Write to J[0][1] in the very cycle column 1 of row 0 is read.
        do_reset();
        write_w(0, 1, 5);
        fork
            run_updates(5, 4'b0010);
            begin
                repeat (2) @(posedge clk);
                #1;
                write_w(0, 1, 20);
            end
        join
        wait_idle();

        // run dropped at cycle 3.
        do_reset();
        write_w(0, 1, 5);
        write_w(0, 2, -3);
        m   = 4'b0110;
        run = 1'b1;
        push_exp(cyc + UPD);
        repeat (3) @(posedge clk);
        #1;
        run = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_eq("busy_cycle7", int'(busy), 0);
        repeat (20) @(posedge clk);
        #1;
        wait_idle();

        // Reset in the middle of an update: no pulse may follow.
        write_w(0, 1, 40);
        m   = 4'b1111;
        run = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_eq("async_busy", int'(busy), 0);
        check_eq("async_enable", int'(pbit_enable), 0);
        check_eq("async_iout", int'(I_out), 0);
        do_reset();
        repeat (15) @(posedge clk);
        #1;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pbit_synapse_scheduler.md
PBIT_SYNAPSE_SCHEDULER -- requirements
Module: pbit_synapse_scheduler

Interface
REQ-001 Parameter N_PBITS, default 4: number of p-bits in the network (2..64).
REQ-002 Parameter W_WIDTH, default 8: signed width of each weight J_ij and bias h_i.
REQ-003 Parameter ACC_WIDTH, default 16: signed accumulator width; SHALL be >= W_WIDTH+clog2(N_PBITS)+2, else elaboration error.
REQ-004 clk  input  1  single clock; all state changes on posedge clk.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 run  input  1  high = continuously sweep updates; low = stop after current update.
REQ-007 m  input  N_PBITS  current p-bit states m_j (1 = +1, 0 = -1).
REQ-008 wr_en  input  1  weight/bias write strobe, one write per cycle.
REQ-009 wr_bias  input  1  1 = write h[wr_row], 0 = write J[wr_row][wr_col].
REQ-010 wr_row, wr_col  input  clog2(N_PBITS) each  write address.
REQ-011 wr_data  input  W_WIDTH signed  write value.
REQ-012 I_out  output  8 signed  weighted input for the p-bit being enabled.
REQ-013 pbit_enable  output  N_PBITS  one-hot update strobe to the p-bit array.
REQ-014 busy  output  1  high whenever FSM is not IDLE.

Function
REQ-015 FSM states IDLE, ACCUM, SAT, ISSUE; IDLE->ACCUM when run=1 sampled in IDLE.
REQ-016 ACCUM SHALL last exactly N_PBITS cycles, column j=0..N_PBITS-1, one per cycle; acc += J[i][j] if m[j]=1, acc -= J[i][j] if m[j]=0, with m sampled live in that cycle.
REQ-017 Diagonal term j==i SHALL contribute 0 regardless of J[i][i].
REQ-018 acc SHALL be preloaded with h[i] (sign-extended) on entry to ACCUM.
REQ-019 SAT (1 cycle): I_out register <= acc clamped to [-128,+127].
REQ-020 ISSUE (1 cycle): pbit_enable[i]=1, all other bits 0; I_out holds the SAT value and stays stable until the next SAT.
REQ-021 Latency: run sampled at cycle 0 -> enable pulse at cycle N_PBITS+2; back-to-back updates every N_PBITS+2 cycles.
REQ-022 After ISSUE, i increments, wrapping N_PBITS-1 -> 0; ISSUE->ACCUM if run=1, else ->IDLE.
REQ-023 run deasserted mid-update SHALL NOT abort; the current update completes through ISSUE.
REQ-024 pbit_enable SHALL be all-zero outside ISSUE.
REQ-025 Writes accepted in any state; a write to the entry read in the same cycle SHALL yield the old value for that read, the new value thereafter.
REQ-026 Out-of-range wr_row/wr_col (>= N_PBITS) writes SHALL be ignored.

Reset
REQ-027 reset SHALL asynchronously force: FSM IDLE, i=0, acc=0, I_out=0, pbit_enable=0, busy=0, all J and h =0.
REQ-028 reset asserted mid-update SHALL discard the partial sum; no enable pulse is issued.

Configuration
REQ-029 Macro PBIT_SYNAPSE_BIAS_EN defined: bias storage present per REQ-018.
REQ-030 Macro undefined: no bias registers, acc preload = 0, wr_en with wr_bias=1 ignored.

Structure
REQ-031 Shared package pbit_pkg: FSM state enum, default widths, saturation bounds (-128/+127), clog2-based index width helper.
REQ-032 One sub-module synapse_mac: signed add/subtract accumulator with clear/preload and clamp-to-8-bit output.

Verification (N_PBITS=4)
REQ-033 Reset: after reset, I_out=0, pbit_enable=0, busy=0; an update with m=4'b1111 yields I_out=0.
REQ-034 J[0][1]=5, J[0][2]=-3, others 0, m=4'b0110, run at cycle 0 -> cycle 6 pbit_enable=4'b0001, I_out=+2.
REQ-035 J[0][1..3]=100: m=4'b1110 -> I_out=+127; m=4'b0000 -> I_out=-128.
REQ-036 J[1][1]=50, row 1 otherwise 0 -> second update: pbit_enable=4'b0010, I_out=0.
REQ-037 run dropped at cycle 3 -> enable pulse still at cycle 6, then busy=0 at cycle 7, no further pulses.
REQ-038 With PBIT_SYNAPSE_BIAS_EN, h[0]=10 plus REQ-034 weights -> I_out=+12; without macro -> +2.
